// File: rtl/differentiator_pkg.sv
// Shared types for the CIC comb stage: tagged sample structs, FSM states and packing helpers.
package differentiator_types;

    localparam int unsigned DEF_W = 10;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default-width views of the tagged streams; the top re-declares them at its own W.
    typedef struct packed {
        logic [0:0]              tag;
        logic signed [DEF_W-1:0] payload;
    } maybe_in;

    typedef struct packed {
        logic [0:0]            tag;
        logic signed [DEF_W:0] payload;
    } maybe_out;

    function automatic logic [DEF_W:0] to_lv_in(input maybe_in m);
        return m;
    endfunction

    function automatic logic [DEF_W+1:0] to_lv_out(input maybe_out m);
        return m;
    endfunction

endpackage

// File: rtl/differentiator_delay.sv
// Delay line of the last M kept samples; only the oldest entry is visible.
module comb_delay_line #(
    parameter int unsigned W = 10,
    parameter int unsigned M = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                shift,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] oldest
);

    logic signed [W-1:0] line [M];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(M); i++) begin
                line[i] <= '0;
            end
        end else if (en && shift) begin
            line[0] <= din;
            for (int i = 1; i < int'(M); i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign oldest = line[M-1];

endmodule

// File: rtl/differentiator.sv
// CIC comb stage: optional decimate-by-R, then first difference with delay M, one bit of growth.
module differentiator
    import differentiator_types::*;
#(
    parameter int unsigned W = 10,
    parameter int unsigned R = 1,
    parameter int unsigned M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W:0]   x,
    output logic [W+1:0] y
);

    localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned FW = $clog2(M + 1);

    typedef struct packed {
        logic [0:0]          tag;
        logic signed [W-1:0] payload;
    } maybe_in_t;

    typedef struct packed {
        logic [0:0]        tag;
        logic signed [W:0] payload;
    } maybe_out_t;

    maybe_in_t           xin;
    maybe_out_t          y_q;
    logic [CW-1:0]       cnt;
    logic [FW-1:0]       fill;
    state_t              state;
    logic signed [W-1:0] oldest;

    logic                accept_c;
    logic                keep_c;
    logic signed [W:0]   diff_c;

    assign xin      = x;
    assign accept_c = en & xin.tag[0];
    assign keep_c   = accept_c && (cnt == CW'(R - 1));

    // Both operands sign-extended by one bit, so the difference can never wrap.
    assign diff_c = $signed({xin.payload[W-1], xin.payload})
                  - $signed({oldest[W-1], oldest});

    comb_delay_line #(
        .W (W),
        .M (M)
    ) u_line (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .shift  (keep_c),
        .din    (xin.payload),
        .oldest (oldest)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            fill  <= '0;
            state <= FILL;
            y_q   <= '0;
        end else if (en) begin
            y_q.tag <= 1'b0;
            if (accept_c) begin
                cnt <= (cnt == CW'(R - 1)) ? '0 : cnt + CW'(1);
            end
            if (keep_c) begin
                case (state)
                    FILL: begin
                        fill <= fill + FW'(1);
                        if (fill == FW'(M - 1)) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        y_q.tag     <= 1'b1;
                        y_q.payload <= diff_c;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    assign y = y_q;

endmodule
